bus_responder: RTL and testbench
================================

Name: bus_responder

Overview:
- Target-side end of the two-queue request bus.
- Accepts the granted queue's output request (address, read/write flag, source queue id) and models a small memory: each write bumps a per-address version counter, and each read returns that address's version after a fixed latency.
- Read responses carry the source id and address back so the bench can check read-after-write ordering end to end.
- Raises a busy flag so the arbiter stops granting while the read FIFO is full.

Parameters:
- WIDTH, 2, address width (matches queue address width)
- DWIDTH, 4, version/data width per address
- DEPTH, 4, read pending FIFO entries
- LOGDEPTH, 2, log2(DEPTH)
- LATENCY, 2, cycles of WAIT per read; must be >= 1

Ports:
- clock  in  1  single clock, posedge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present this cycle (queue validout qualified by grant)
- req_isread  in  1  1 = read, 0 = write
- req_src  in  1  issuing queue id (0/1)
- req_addr  in  WIDTH  request address
- resp_ready  in  1  consumer accepts response this cycle
- req_busy  out  1  read FIFO full; arbiter must not grant
- resp_valid  out  1  read response valid
- resp_src  out  1  source id of response
- resp_addr  out  WIDTH  address of response
- resp_data  out  DWIDTH  version of resp_addr sampled at read acceptance
- overflow  out  1  sticky: a read arrived while FIFO full
- outstanding  out  LOGDEPTH+1  reads accepted but not yet handshaken

Behaviour:
- Reset (async, reset_n=0): all versions=0, FIFO empty, FSM=R_IDLE, resp_valid=0, resp_src=0, resp_addr=0, resp_data=0, overflow=0, req_busy=0, outstanding=0. Assertion mid-operation discards all pending reads immediately.
- Write accept: req_valid & !req_isread; always accepted, never blocked by busy. version[req_addr] <= version[req_addr]+1 at that edge, mod 2^DWIDTH (wraps to 0).
- Read accept: req_valid & req_isread & (count<DEPTH).
  - Push {src, addr, version[addr]} into FIFO.
  - Data is snapshotted at acceptance, so the read reflects every earlier-accepted write and no later one.
- Read while count==DEPTH (evaluated before this edge's pop): request dropped, overflow <= 1 (sticky until reset), no other state change.
- req_busy = (count==DEPTH); combinational from registered count.
- FIFO: count is LOGDEPTH+1 bits; head/tail pointers wrap mod DEPTH. Push and pop on the same edge are legal at any count, including the full case; count is unchanged.
- FSM (states R_IDLE, R_WAIT, R_RESP):
  - R_IDLE: if FIFO nonempty, pop head into response registers, cnt <= LATENCY, go R_WAIT. A read pushed into an empty FIFO is not visible to the pop until the next edge.
  - R_WAIT: if cnt==1, go R_RESP; else cnt <= cnt-1.
  - R_RESP: resp_valid=1; response registers held stable while resp_ready=0. On resp_valid & resp_ready: if FIFO nonempty, pop next entry, cnt <= LATENCY, go R_WAIT (back-to-back); else go R_IDLE.
- Latency: read accepted at edge k into an idle, empty responder gives resp_valid high starting after edge k+LATENCY+1. Steady-state throughput is one response per LATENCY+1 cycles.
- resp_valid is high only in R_RESP. resp_src/resp_addr/resp_data hold their last value outside R_RESP.
- outstanding = count + (state != R_IDLE).

Decomposition:
- Shared package twoq_pkg:
  - typedef enum resp_states {R_IDLE, R_WAIT, R_RESP}
  - FIFO entry field layout constants (SRC bit, ADDR, DATA slice positions)
- One sub-module, resp_fifo: parameterised DEPTH/LOGDEPTH FIFO with push, pop, count, full, empty, async active-low reset.
- Version array and FSM live in bus_responder.

Test Plan:
- Reset, then read src=0 addr=1 at edge 0 (LATENCY=2) -> resp_valid rises after edge 3 with src=0, addr=1, data=0; outstanding=1 until the handshake edge, then 0.
- Writes to addr=2 on three consecutive edges, then read addr=2 -> resp_data=3. After 16 further writes to addr=2 (DWIDTH=4), a read returns 3 (wrap).
- Write addr=3, then read addr=3 on the next edge, then write addr=3 on the edge after -> resp_data=1, not 2 (snapshot at acceptance).
- Hold resp_ready=0 and issue 5 reads (DEPTH=4, one popped into WAIT) -> req_busy=1 when count reaches 4; a further read sets overflow=1 and is never responded to. Release resp_ready -> exactly 5 responses in issue order.
- Pulse reset_n low while in R_WAIT with 2 reads queued -> resp_valid=0, outstanding=0, overflow=0 immediately. Next read of any address returns data=0.
- resp_ready=1 continuously with 4 back-to-back reads -> responses spaced exactly LATENCY+1=3 cycles apart, with no R_IDLE cycle between them.

Source files
------------

// File: rtl/twoq_pkg.sv
// twoq_pkg: shared types and response-FIFO entry layout for the two-queue request bus.
// Entry layout, MSB to LSB: {src, addr, data}.
package twoq_pkg;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} resp_states;

    localparam int DATA_LSB = 0;

    function automatic int addr_lsb(input int dw);
        return dw;
    endfunction

    function automatic int src_bit(input int w, input int dw);
        return w + dw;
    endfunction

    function automatic int entry_w(input int w, input int dw);
        return w + dw + 1;
    endfunction

endpackage

// File: rtl/bus_responder_resp_fifo.sv
// resp_fifo: pending-read FIFO with registered count; push and pop may share an edge at any fill level.
module resp_fifo #(
    parameter int EW       = 7,
    parameter int DEPTH    = 4,
    parameter int LOGDEPTH = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                push,
    input  logic                pop,
    input  logic [EW-1:0]       din,
    output logic [EW-1:0]       dout,
    output logic [LOGDEPTH:0]   count,
    output logic                full,
    output logic                empty
);

    logic [EW-1:0]       mem_q [DEPTH];
    logic [LOGDEPTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [LOGDEPTH:0]   count_q, count_d;

    always_comb begin
        head_d  = !pop ? head_q : head_q == LOGDEPTH'(DEPTH - 1) ? '0 : head_q + 1'b1;
        tail_d  = !push ? tail_q : tail_q == LOGDEPTH'(DEPTH - 1) ? '0 : tail_q + 1'b1;
        count_d = count_q + (LOGDEPTH + 1)'(push) - (LOGDEPTH + 1)'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is only read once count says the slot is valid, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push) mem_q[tail_q] <= din;
    end

    assign dout  = mem_q[head_q];
    assign count = count_q;
    assign full  = count_q == (LOGDEPTH + 1)'(DEPTH);
    assign empty = count_q == '0;

endmodule

// File: rtl/bus_responder.sv
// bus_responder: target end of the two-queue bus; versioned memory model with fixed-latency read responses.
module bus_responder
    import twoq_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int DWIDTH   = 4,
    parameter int DEPTH    = 4,
    parameter int LOGDEPTH = 2,
    parameter int LATENCY  = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    input  logic                req_isread,
    input  logic                req_src,
    input  logic [WIDTH-1:0]    req_addr,
    input  logic                resp_ready,
    output logic                req_busy,
    output logic                resp_valid,
    output logic                resp_src,
    output logic [WIDTH-1:0]    resp_addr,
    output logic [DWIDTH-1:0]   resp_data,
    output logic                overflow,
    output logic [LOGDEPTH:0]   outstanding
);

    localparam int EW = entry_w(WIDTH, DWIDTH);
    localparam int AL = addr_lsb(DWIDTH);
    localparam int SB = src_bit(WIDTH, DWIDTH);
    localparam int CW = $clog2(LATENCY + 1);

    logic [DWIDTH-1:0] ver_q [2**WIDTH];
    logic [DWIDTH-1:0] ver_d [2**WIDTH];
    resp_states        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [EW-1:0]     resp_q, resp_d, head;
    logic              overflow_q, overflow_d;
    logic              push, pop, full, empty;
    logic [LOGDEPTH:0] count;

    // Data is captured at acceptance, so later writes never leak into a pending read.
    assign push = req_valid & req_isread & !full;

    resp_fifo #(.EW(EW), .DEPTH(DEPTH), .LOGDEPTH(LOGDEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     ({req_src, req_addr, ver_q[req_addr]}),
        .dout    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        ver_d = ver_q;
        if (req_valid && !req_isread) ver_d[req_addr] = ver_q[req_addr] + 1'b1;
        overflow_d = overflow_q | (req_valid & req_isread & full);
        cnt_d      = pop ? CW'(LATENCY) : state_q == R_WAIT ? cnt_q - 1'b1 : cnt_q;
        resp_d     = pop ? head : resp_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ver_q      <= '{default: '0};
            cnt_q      <= '0;
            resp_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            ver_q      <= ver_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= R_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  state_d = empty ? R_IDLE : R_WAIT;
            R_WAIT:  state_d = cnt_q == CW'(1) ? R_RESP : R_WAIT;
            R_RESP:  state_d = !resp_ready ? R_RESP : empty ? R_IDLE : R_WAIT;
            default: state_d = R_IDLE;
        endcase
    end

    // Popping straight out of R_RESP keeps responses back-to-back without an idle cycle.
    always_comb begin
        resp_valid = state_q == R_RESP;
        pop        = !empty && (state_q == R_IDLE || (state_q == R_RESP && resp_ready));
    end

    assign resp_src    = resp_q[SB];
    assign resp_addr   = resp_q[AL +: WIDTH];
    assign resp_data   = resp_q[DATA_LSB +: DWIDTH];
    assign req_busy    = full;
    assign overflow    = overflow_q;
    assign outstanding = count + (LOGDEPTH + 1)'(state_q != R_IDLE);

endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed stimulus with a scoreboard of expected {src, addr, data} read responses.
module tb_bus_responder;

    logic       clock, reset_n;
    logic       req_valid, req_isread, req_src, resp_ready;
    logic [1:0] req_addr;
    logic       req_busy, resp_valid, resp_src, overflow;
    logic [1:0] resp_addr;
    logic [3:0] resp_data;
    logic [2:0] outstanding;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nresp = 0;
    logic [6:0] exp_q [$];
    int resp_cyc [$];
    logic [3:0] ver [4];

    bus_responder #(
        .WIDTH(2), .DWIDTH(4), .DEPTH(4), .LOGDEPTH(2), .LATENCY(2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_isread  (req_isread),
        .req_src     (req_src),
        .req_addr    (req_addr),
        .resp_ready  (resp_ready),
        .req_busy    (req_busy),
        .resp_valid  (resp_valid),
        .resp_src    (resp_src),
        .resp_addr   (resp_addr),
        .resp_data   (resp_data),
        .overflow    (overflow),
        .outstanding (outstanding)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic rd, input logic src, input logic [1:0] addr, input bit drop = 1'b0);
        req_valid  = 1'b1;
        req_isread = rd;
        req_src    = src;
        req_addr   = addr;
        if (!rd) ver[addr] = ver[addr] + 4'd1;
        else if (!drop) exp_q.push_back({src, addr, ver[addr]});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk("drain", exp_q.size(), 0);
        tick();
    endtask

    always @(negedge clock) begin
        if (reset_n && resp_valid && resp_ready) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                chk("resp", {resp_src, resp_addr, resp_data}, exp_q.pop_front());
                resp_cyc.push_back(cyc);
                nresp++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n0;
        reset_n = 1'b0; req_valid = 1'b0; req_isread = 1'b0; req_src = 1'b0;
        req_addr = '0; resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) ver[i] = '0;
        #2;
        chk("rst_valid", resp_valid, 0);
        chk("rst_busy", req_busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_resp", {resp_src, resp_addr, resp_data}, 0);
        @(posedge clock); #1 reset_n = 1'b1;

        // Latency: read at edge 0, response visible after edge 3, held while not ready.
        req(1'b1, 1'b0, 2'd1);
        chk("lat_out_e0", outstanding, 1);
        chk("lat_valid_e0", resp_valid, 0);
        tick(); chk("lat_valid_e1", resp_valid, 0);
        tick(); chk("lat_valid_e2", resp_valid, 0);
        tick(); chk("lat_valid_e3", resp_valid, 1);
        chk("lat_resp_e3", {resp_src, resp_addr, resp_data}, {1'b0, 2'd1, 4'd0});
        tick(); chk("hold_valid", resp_valid, 1);
        chk("hold_resp", {resp_src, resp_addr, resp_data}, {1'b0, 2'd1, 4'd0});
        chk("hold_out", outstanding, 1);
        resp_ready = 1'b1;
        tick();
        chk("hs_valid", resp_valid, 0);
        chk("hs_out", outstanding, 0);
        chk("hs_sb", exp_q.size(), 0);

        // Version counting and wrap.
        repeat (3) req(1'b0, 1'b0, 2'd2);
        req(1'b1, 1'b1, 2'd2);
        drain();
        repeat (16) req(1'b0, 1'b1, 2'd2);
        req(1'b1, 1'b0, 2'd2);
        drain();

        // Snapshot at acceptance.
        req(1'b0, 1'b0, 2'd3);
        req(1'b1, 1'b1, 2'd3);
        req(1'b0, 1'b0, 2'd3);
        drain();

        // Fill FIFO with response stalled, then overflow.
        resp_ready = 1'b0;
        req(1'b1, 1'b0, 2'd0);
        req(1'b1, 1'b1, 2'd1);
        req(1'b1, 1'b0, 2'd2);
        req(1'b1, 1'b1, 2'd3);
        req(1'b1, 1'b0, 2'd2);
        chk("full_busy", req_busy, 1);
        chk("full_out", outstanding, 5);
        chk("full_ovf_pre", overflow, 0);
        req(1'b1, 1'b1, 2'd0, 1'b1);
        chk("ovf_set", overflow, 1);
        chk("ovf_busy", req_busy, 1);
        chk("ovf_out", outstanding, 5);
        n0 = nresp;
        resp_ready = 1'b1;
        drain();
        chk("ovf_nresp", nresp - n0, 5);
        chk("ovf_busy_clr", req_busy, 0);
        chk("ovf_out_clr", outstanding, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset while in R_WAIT with two reads queued.
        req(1'b1, 1'b0, 2'd1);
        req(1'b1, 1'b1, 2'd2);
        req(1'b1, 1'b0, 2'd3);
        chk("pre_rst_out", outstanding, 3);
        reset_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) ver[i] = '0;
        #1;
        chk("arst_valid", resp_valid, 0);
        chk("arst_out", outstanding, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_busy", req_busy, 0);
        tick();
        reset_n = 1'b1;
        req(1'b1, 1'b1, 2'd2);
        drain();

        // Back-to-back throughput.
        resp_cyc.delete();
        for (int i = 0; i < 4; i++) req(1'b1, i[0], 2'(i));
        drain();
        chk("b2b_count", resp_cyc.size(), 4);
        for (int i = 1; i < 4 && i < resp_cyc.size(); i++)
            chk("b2b_gap", resp_cyc[i] - resp_cyc[i-1], 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
